pipeline_hazard_ctrl: RTL and testbench

- Central stall/flush/enable sequencer for the 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.
- Detects load-use hazards and branch-taken flushes.
- Freezes the whole pipeline while a multi-cycle data-memory access in MEM is outstanding.
- Flags a sticky error on memory timeout and keeps saturating stall/flush performance counters.

---
 rtl/pipeline_hazard_ctrl.sv | 155 +++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - pipeline stall/flush/enable sequencer with memory-freeze timeout
module pipeline_hazard_ctrl #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             IDEX_MemRead_i,
   input  logic [4:0]       IDEX_RdAddr_i,
   input  logic [4:0]       IFID_Rs1Addr_i,
   input  logic [4:0]       IFID_Rs2Addr_i,
   input  logic             branch_taken_i,
   input  logic             mem_req_i,
   input  logic             mem_ack_i,
   output logic             PC_write_o,
   output logic             IFID_write_o,
   output logic             IFID_flush_o,
   output logic             IDEX_write_o,
   output logic             IDEX_bubble_o,
   output logic             EXMEM_write_o,
   output logic             MEMWB_write_o,
   output logic             mem_busy_o,
   output logic             error_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o
);

   localparam int WC_W = $clog2(MEM_TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, RUN, MEM_WAIT, ERROR} state_e;

   state_e           state_q, state_d;
   logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic             error_q, error_d;
   logic             freeze_req;
   logic             load_use;
   logic             stall_evt;

   assign freeze_req = mem_req_i & ~mem_ack_i;
   // x0 is hardwired zero, so a load targeting it never creates a dependency
   assign load_use = IDEX_MemRead_i && (IDEX_RdAddr_i != 5'd0) &&
                     ((IDEX_RdAddr_i == IFID_Rs1Addr_i) || (IDEX_RdAddr_i == IFID_Rs2Addr_i));

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         wait_cnt_q  <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
         error_q     <= error_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      error_d    = error_q;
      case (state_q)
         IDLE: begin
            if (start_i) state_d = RUN;
         end
         RUN: begin
            if (freeze_req) begin
               state_d    = MEM_WAIT;
               wait_cnt_d = WC_W'(1);
            end else if (!start_i) begin
               state_d = IDLE;
            end
         end
         MEM_WAIT: begin
            if (mem_ack_i) begin
               state_d    = start_i ? RUN : IDLE;
               wait_cnt_d = '0;
            end else if (wait_cnt_q == WC_W'(MEM_TIMEOUT)) begin
               state_d = ERROR;
               error_d = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + WC_W'(1);
            end
         end
         ERROR: begin
            error_d = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      PC_write_o    = 1'b0;
      IFID_write_o  = 1'b0;
      IFID_flush_o  = 1'b0;
      IDEX_write_o  = 1'b0;
      IDEX_bubble_o = 1'b0;
      EXMEM_write_o = 1'b0;
      MEMWB_write_o = 1'b0;
      mem_busy_o    = 1'b0;
      stall_evt     = 1'b0;
      case (state_q)
         RUN: begin
            if (freeze_req) begin
               mem_busy_o = 1'b1;
               stall_evt  = 1'b1;
            end else if (load_use) begin
               IDEX_write_o  = 1'b1;
               IDEX_bubble_o = 1'b1;
               EXMEM_write_o = 1'b1;
               MEMWB_write_o = 1'b1;
               stall_evt     = 1'b1;
            end else begin
               PC_write_o    = 1'b1;
               IFID_write_o  = 1'b1;
               IFID_flush_o  = branch_taken_i;
               IDEX_write_o  = 1'b1;
               EXMEM_write_o = 1'b1;
               MEMWB_write_o = 1'b1;
            end
         end
         MEM_WAIT: begin
            // release cycle ignores hazards; they are re-evaluated once back in RUN
            if (mem_ack_i) begin
               PC_write_o    = 1'b1;
               IFID_write_o  = 1'b1;
               IDEX_write_o  = 1'b1;
               EXMEM_write_o = 1'b1;
               MEMWB_write_o = 1'b1;
            end else begin
               mem_busy_o = 1'b1;
               stall_evt  = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (stall_evt && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (IFID_flush_o && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
   end

   assign error_o     = error_q;
   assign stall_cnt_o = stall_cnt_q;
   assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

   localparam int CNT_W = 3;

   // {PC_w, IFID_w, IFID_flush, IDEX_w, IDEX_bubble, EXMEM_w, MEMWB_w, mem_busy}
   localparam logic [7:0] CTL_ZERO   = 8'b0000_0000;
   localparam logic [7:0] CTL_RUN    = 8'b1101_0110;
   localparam logic [7:0] CTL_FLUSH  = 8'b1111_0110;
   localparam logic [7:0] CTL_STALL  = 8'b0001_1110;
   localparam logic [7:0] CTL_FREEZE = 8'b0000_0001;

   logic             clk_i = 1'b0;
   logic             rst_i;
   logic             start_i;
   logic             IDEX_MemRead_i;
   logic [4:0]       IDEX_RdAddr_i;
   logic [4:0]       IFID_Rs1Addr_i;
   logic [4:0]       IFID_Rs2Addr_i;
   logic             branch_taken_i;
   logic             mem_req_i;
   logic             mem_ack_i;
   logic             PC_write_o;
   logic             IFID_write_o;
   logic             IFID_flush_o;
   logic             IDEX_write_o;
   logic             IDEX_bubble_o;
   logic             EXMEM_write_o;
   logic             MEMWB_write_o;
   logic             mem_busy_o;
   logic             error_o;
   logic [CNT_W-1:0] stall_cnt_o;
   logic [CNT_W-1:0] flush_cnt_o;
   logic [7:0]       ctl;

   int n_cmp = 0;
   int n_err = 0;

   pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
      .IDEX_MemRead_i(IDEX_MemRead_i), .IDEX_RdAddr_i(IDEX_RdAddr_i),
      .IFID_Rs1Addr_i(IFID_Rs1Addr_i), .IFID_Rs2Addr_i(IFID_Rs2Addr_i),
      .branch_taken_i(branch_taken_i), .mem_req_i(mem_req_i), .mem_ack_i(mem_ack_i),
      .PC_write_o(PC_write_o), .IFID_write_o(IFID_write_o), .IFID_flush_o(IFID_flush_o),
      .IDEX_write_o(IDEX_write_o), .IDEX_bubble_o(IDEX_bubble_o),
      .EXMEM_write_o(EXMEM_write_o), .MEMWB_write_o(MEMWB_write_o),
      .mem_busy_o(mem_busy_o), .error_o(error_o),
      .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
   );

   assign ctl = {PC_write_o, IFID_write_o, IFID_flush_o, IDEX_write_o,
                 IDEX_bubble_o, EXMEM_write_o, MEMWB_write_o, mem_busy_o};

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic clr_in();
      IDEX_MemRead_i = 1'b0;
      IDEX_RdAddr_i  = 5'd0;
      IFID_Rs1Addr_i = 5'd0;
      IFID_Rs2Addr_i = 5'd0;
      branch_taken_i = 1'b0;
      mem_req_i      = 1'b0;
      mem_ack_i      = 1'b0;
   endtask

   // leaves the DUT in RUN, one tick after the IDLE->RUN edge
   task automatic do_reset();
      rst_i   = 1'b1;
      start_i = 1'b0;
      clr_in();
      cyc();
      rst_i   = 1'b0;
      start_i = 1'b1;
      cyc();
   endtask

   initial begin
      rst_i   = 1'b1;
      start_i = 1'b0;
      clr_in();
      settle();
      chk("rst_ctl", ctl, CTL_ZERO);
      chk("rst_stall_cnt", stall_cnt_o, 0);
      chk("rst_flush_cnt", flush_cnt_o, 0);
      chk("rst_error", error_o, 0);

      cyc();
      rst_i   = 1'b0;
      start_i = 1'b1;
      settle();
      chk("idle_ctl", ctl, CTL_ZERO);
      cyc();
      settle();
      chk("run_ctl", ctl, CTL_RUN);

      // load-use on rs1
      IDEX_MemRead_i = 1'b1; IDEX_RdAddr_i = 5'd5; IFID_Rs1Addr_i = 5'd5;
      settle();
      chk("lu_ctl", ctl, CTL_STALL);
      chk("lu_cnt_before", stall_cnt_o, 0);
      cyc();
      chk("lu_cnt_after", stall_cnt_o, 1);

      // load to x0 is not a hazard; branch then flushes
      IDEX_RdAddr_i = 5'd0; IFID_Rs1Addr_i = 5'd0; IFID_Rs2Addr_i = 5'd0;
      settle();
      chk("x0_ctl", ctl, CTL_RUN);
      branch_taken_i = 1'b1;
      settle();
      chk("br_ctl", ctl, CTL_FLUSH);
      chk("br_fcnt_before", flush_cnt_o, 0);
      cyc();
      chk("br_fcnt_after", flush_cnt_o, 1);
      chk("br_scnt_same", stall_cnt_o, 1);

      // load-use on rs2 beats a taken branch
      IDEX_RdAddr_i = 5'd5; IFID_Rs2Addr_i = 5'd5;
      settle();
      chk("lu_br_ctl", ctl, CTL_STALL);
      cyc();
      chk("lu_br_scnt", stall_cnt_o, 2);
      chk("lu_br_fcnt", flush_cnt_o, 1);

      // memory wait of 3 freeze cycles then release
      do_reset();
      mem_req_i = 1'b1; mem_ack_i = 1'b0;
      settle();
      chk("mw_ctl_c1", ctl, CTL_FREEZE);
      cyc();
      settle();
      chk("mw_ctl_c2", ctl, CTL_FREEZE);
      cyc();
      IDEX_MemRead_i = 1'b1; IDEX_RdAddr_i = 5'd7; IFID_Rs1Addr_i = 5'd7;
      settle();
      chk("mw_ctl_c3_hazard", ctl, CTL_FREEZE);
      cyc();
      clr_in();
      mem_req_i = 1'b1; mem_ack_i = 1'b1; branch_taken_i = 1'b1;
      settle();
      chk("mw_release_ctl", ctl, CTL_RUN);
      chk("mw_scnt", stall_cnt_o, 3);
      cyc();
      branch_taken_i = 1'b0;
      settle();
      chk("zero_wait_ctl", ctl, CTL_RUN);
      cyc();
      chk("zero_wait_scnt", stall_cnt_o, 3);
      chk("mw_fcnt", flush_cnt_o, 0);

      // timeout with MEM_TIMEOUT=4: error after fifth freeze edge; counter saturates at 7
      mem_ack_i = 1'b0;
      repeat (4) cyc();
      settle();
      chk("to_ctl_c5", ctl, CTL_FREEZE);
      chk("to_err_before", error_o, 0);
      cyc();
      settle();
      chk("to_err_after", error_o, 1);
      chk("to_ctl_err", ctl, CTL_ZERO);
      chk("to_scnt_sat", stall_cnt_o, 7);
      mem_ack_i = 1'b1; start_i = 1'b1;
      settle();
      chk("err_ack_ctl", ctl, CTL_ZERO);
      repeat (2) cyc();
      chk("err_sticky", error_o, 1);
      chk("err_ctl_hold", ctl, CTL_ZERO);

      // asynchronous reset in the second MEM_WAIT cycle
      do_reset();
      chk("err_cleared", error_o, 0);
      mem_req_i = 1'b1; mem_ack_i = 1'b0;
      repeat (2) cyc();
      chk("mid_wait_busy", ctl, CTL_FREEZE);
      chk("mid_wait_scnt", stall_cnt_o, 2);
      #2;
      rst_i = 1'b1;
      #1;
      chk("async_rst_ctl", ctl, CTL_ZERO);
      chk("async_rst_scnt", stall_cnt_o, 0);
      @(posedge clk_i);
      #1;
      clr_in();
      rst_i = 1'b0;
      cyc();
      settle();
      chk("post_rst_run", ctl, CTL_RUN);

      // 9 load-use stall cycles saturate the 3-bit counter
      IDEX_MemRead_i = 1'b1; IDEX_RdAddr_i = 5'd9; IFID_Rs2Addr_i = 5'd9;
      repeat (9) cyc();
      chk("sat_scnt", stall_cnt_o, 7);
      settle();
      chk("sat_still_stall", ctl, CTL_STALL);

      // start low returns to IDLE
      clr_in();
      start_i = 1'b0;
      settle();
      chk("stop_run_ctl", ctl, CTL_RUN);
      cyc();
      settle();
      chk("stop_idle_ctl", ctl, CTL_ZERO);
      cyc();
      chk("stop_idle_hold", ctl, CTL_ZERO);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
